serial_population_counter: RTL and testbench

SERIAL_POPULATION_COUNTER -- requirements
Module: serial_population_counter

---
 rtl/popcount_pkg.sv | 22 ++
 rtl/chunk_popcount.sv | 20 ++
 rtl/serial_population_counter.sv | 116 +++++++++++
 tb/tb_serial_population_counter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared definitions for the serial population counter: FSM encoding and clog2 helper.
package popcount_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Smallest r such that 2**r >= v; usable in constant expressions.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) begin
            r = 32'(i + 1);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/chunk_popcount.sv
// Combinational population count of one CHUNK-bit slice.
module chunk_popcount
   import popcount_pkg::*;
#(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0]              bits_i,
   output logic [clog2(CHUNK+1)-1:0]     count_c
);

   localparam int unsigned CW = clog2(CHUNK + 1);

   always_comb begin
      count_c = '0;
      for (int i = 0; i < int'(CHUNK); i++) begin
         count_c = count_c + CW'(bits_i[i]);
      end
   end

endmodule

// File: rtl/serial_population_counter.sv
// Counts ones (mode=0) or zeros (mode=1) of a WIDTH-bit operand, CHUNK bits per clock.
module serial_population_counter
   import popcount_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          mode,
   input  logic [WIDTH-1:0]              a,
   output logic                          busy,
   output logic                          done,
   output logic [clog2(WIDTH+1)-1:0]     Q
);

   localparam int unsigned QW    = clog2(WIDTH + 1);
   localparam int unsigned NBEAT = WIDTH / CHUNK;
   localparam int unsigned BW    = clog2(NBEAT + 1);
   localparam int unsigned CW    = clog2(CHUNK + 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic               mode_q,  mode_d;
   logic [QW-1:0]      acc_q,   acc_d;
   logic [QW-1:0]      q_q,     q_d;
   logic [BW-1:0]      beat_q,  beat_d;
   logic               busy_q,  busy_d;
   logic               done_q,  done_d;

   logic [CHUNK-1:0]   chunk_c;
   logic [CW-1:0]      chunk_cnt_c;
   logic [QW-1:0]      sum_c;

   // Counting zeros is counting ones of the inverted slice.
   assign chunk_c = mode_q ? ~shift_q[CHUNK-1:0] : shift_q[CHUNK-1:0];

   chunk_popcount #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .bits_i  (chunk_c),
      .count_c (chunk_cnt_c)
   );

   assign sum_c = acc_q + QW'(chunk_cnt_c);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      q_d     = q_q;
      beat_d  = beat_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d = a;
               mode_d  = mode;
               acc_d   = '0;
               beat_d  = BW'(NBEAT);
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d   = sum_c;
            shift_d = shift_q >> CHUNK;
            beat_d  = beat_q - BW'(1);
            if (beat_q == BW'(1)) begin
               q_d     = sum_c;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are registered versions of the next-state decode.
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         mode_q  <= 1'b0;
         acc_q   <= '0;
         q_q     <= '0;
         beat_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         beat_q  <= beat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Q    = q_q;

endmodule

// File: tb/tb_serial_population_counter.sv
// Scoreboard bench for serial_population_counter with CHUNK = 8, 1 and 32.
module tb_serial_population_counter;

   typedef struct {
      logic [5:0]  q;
      int unsigned due;
   } sb_item_t;

   logic             clk;
   logic             rst;
   logic             mode_i;
   logic [31:0]      a_i;
   logic [2:0]       start_w;
   logic             busy_w [3];
   logic             done_w [3];
   logic [5:0]       q_w    [3];

   int unsigned      nbeat  [3] = '{4, 32, 1};
   sb_item_t         sb_q   [3][$];
   logic [5:0]       q_exp  [3];
   int unsigned      busy_run [3];
   int unsigned      cyc;
   int unsigned      n_checks;
   int unsigned      n_fail;
   bit               mon_en;

   serial_population_counter #(.WIDTH(32), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start_w[0]), .mode(mode_i), .a(a_i),
      .busy(busy_w[0]), .done(done_w[0]), .Q(q_w[0]));

   serial_population_counter #(.WIDTH(32), .CHUNK(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_w[1]), .mode(mode_i), .a(a_i),
      .busy(busy_w[1]), .done(done_w[1]), .Q(q_w[1]));

   serial_population_counter #(.WIDTH(32), .CHUNK(32)) u_dut32 (
      .clk(clk), .rst(rst), .start(start_w[2]), .mode(mode_i), .a(a_i),
      .busy(busy_w[2]), .done(done_w[2]), .Q(q_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the expected result whenever a done pulse appears.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         for (int k = 0; k < 3; k++) begin
            if (done_w[k]) begin
               if (sb_q[k].size() == 0) begin
                  check($sformatf("unexpected_done_%0d", k), 1, 0);
               end else begin
                  sb_item_t it;
                  it = sb_q[k].pop_front();
                  check($sformatf("result_%0d", k), q_w[k], it.q);
                  check($sformatf("done_cycle_%0d", k), cyc, it.due);
                  check($sformatf("busy_len_%0d", k), busy_run[k], nbeat[k]);
                  check($sformatf("busy_in_done_%0d", k), busy_w[k], 0);
                  q_exp[k] = it.q;
               end
               busy_run[k] = 0;
            end else begin
               check($sformatf("q_hold_%0d", k), q_w[k], q_exp[k]);
               if (busy_w[k]) busy_run[k]++;
            end
         end
      end
   end

   // Issue one start to instance k; returns with that instance in its DONE cycle.
   task automatic run(input int k, input logic [31:0] av, input logic mv, input logic [5:0] exp);
      sb_item_t it;
      @(negedge clk);
      a_i        = av;
      mode_i     = mv;
      start_w[k] = 1'b1;
      it.q       = exp;
      it.due     = cyc + 1 + nbeat[k];
      sb_q[k].push_back(it);
      @(negedge clk);
      start_w[k] = 1'b0;
      a_i        = ~av;
      mode_i     = ~mv;
      repeat (nbeat[k]) @(negedge clk);
   endtask

   initial begin
      logic [31:0] vec_cont [3];
      logic [5:0]  exp_cont [3];
      sb_item_t    it;
      vec_cont = '{32'hFFFF0000, 32'h00000007, 32'h0000000F};
      exp_cont = '{6'd16, 6'd3, 6'd4};

      rst = 1'b1; start_w = '0; a_i = '0; mode_i = 1'b0;
      n_checks = 0; n_fail = 0; mon_en = 1'b0; cyc = 0;
      for (int k = 0; k < 3; k++) begin q_exp[k] = '0; busy_run[k] = 0; end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_q_%0d", k), q_w[k], 0);
         check($sformatf("reset_busy_%0d", k), busy_w[k], 0);
         check($sformatf("reset_done_%0d", k), done_w[k], 0);
      end
      mon_en = 1'b1;

      run(0, 32'hFFFFFFFF, 1'b0, 6'd32);
      run(0, 32'b11010001100010101011011000100110, 1'b0, 6'd15);
      run(0, 32'b11010001100010101011011000100110, 1'b1, 6'd17);
      run(0, 32'h00000000, 1'b0, 6'd0);
      run(0, 32'h00000000, 1'b1, 6'd32);
      run(0, 32'hA5A50F01, 1'b0, 6'd13);
      run(0, 32'h80000001, 1'b1, 6'd30);

      // Start held high: acceptances must come every NBEAT+2 cycles.
      @(negedge clk);
      mode_i     = 1'b0;
      start_w[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_i    = vec_cont[i];
         it.q   = exp_cont[i];
         it.due = cyc + 1 + nbeat[0];
         sb_q[0].push_back(it);
         repeat (nbeat[0] + 2) @(negedge clk);
      end
      start_w[0] = 1'b0;

      // Reset in the second RUN beat aborts the count.
      run(0, 32'h0000FFFF, 1'b0, 6'd16);
      @(negedge clk);
      a_i = 32'hFFFFFFFF; mode_i = 1'b0; start_w[0] = 1'b1;
      @(negedge clk);
      start_w[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sb_q[k].delete(); q_exp[k] = '0; busy_run[k] = 0;
      end
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy_w[0], 0);
      check("abort_done", done_w[0], 0);
      check("abort_q", q_w[0], 0);
      repeat (8) @(negedge clk);
      run(0, 32'h12345678, 1'b0, 6'd13);
      run(0, 32'h12345678, 1'b1, 6'd19);

      run(1, 32'hFFFFFFFF, 1'b0, 6'd32);
      run(2, 32'hFFFFFFFF, 1'b0, 6'd32);
      run(1, 32'h12345678, 1'b1, 6'd19);
      run(2, 32'hA5A50F01, 1'b0, 6'd13);
      run(2, 32'h00000000, 1'b1, 6'd32);

      repeat (4) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("sb_drain_%0d", k), sb_q[k].size(), 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
